if_stage: RTL and testbench

// - Instruction fetch stage directly upstream of the decoder. Holds the PC,

---
 rtl/if_stage.sv | 195 +++++++++++++++++++
 tb/tb_if_stage.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
// Instruction fetch stage: PC, in-order imem requests, response FIFO toward decode.
// Optional IF_MISALIGN_EN: misaligned redirects raise fetch_misalign and halt fetch.
module if_stage #(
  parameter logic [31:0] RESET_PC        = 32'h8000_0000,
  parameter int          FIFO_DEPTH      = 4,
  parameter int          MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        fetch_misalign
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int TAG_W = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

`ifdef IF_MISALIGN_EN
  typedef enum logic [1:0] {S_RUN = 2'd0, S_DRAIN = 2'd1, S_HALT = 2'd2} state_e;
`else
  typedef enum logic [1:0] {S_RUN = 2'd0, S_DRAIN = 2'd1} state_e;
`endif

  state_e             state_q, state_d;
  logic [31:0]        pc_q, pc_d;
  logic [CNT_W-1:0]   out_q, out_d;
  logic [CNT_W-1:0]   drop_q, drop_d;
  logic               req_valid_q, req_valid_d;
  logic               misalign_q, misalign_d;
  logic [CNT_W-1:0]   fifo_wr_q, fifo_wr_d, fifo_rd_q, fifo_rd_d;
  logic [TAG_W-1:0]   tag_wr_q, tag_wr_d, tag_rd_q, tag_rd_d;
  logic [31:0]        fifo_inst_q [FIFO_DEPTH];
  logic [31:0]        fifo_pc_q   [FIFO_DEPTH];
  logic [31:0]        tag_pc_q    [MAX_OUTSTANDING];

  logic               req_fire_s, rsp_fire_s, redirect_s, pop_s;
  logic               fifo_push_s, tag_push_s;
  logic [CNT_W-1:0]   fifo_cnt_s, fifo_cnt_d;
  logic [CNT_W:0]     sum_d;
  logic               unused_s;

  function automatic logic [TAG_W-1:0] tag_inc(input logic [TAG_W-1:0] p);
    if (p == TAG_W'(MAX_OUTSTANDING - 1)) begin
      return '0;
    end else begin
      return p + TAG_W'(1);
    end
  endfunction

  assign req_fire_s     = req_valid_q && imem_req_ready;
  assign rsp_fire_s     = imem_rsp_valid;
  assign fifo_cnt_s     = fifo_wr_q - fifo_rd_q;
  assign inst_valid     = (fifo_cnt_s != '0) && !redirect_valid;
  assign pop_s          = inst_valid && inst_ready;
  assign inst           = fifo_inst_q[fifo_rd_q[PTR_W-1:0]];
  assign inst_pc        = fifo_pc_q[fifo_rd_q[PTR_W-1:0]];
  assign imem_req_valid = req_valid_q;
  assign imem_req_addr  = pc_q;
  assign unused_s       = ^redirect_pc[1:0];

`ifdef IF_MISALIGN_EN
  assign redirect_s     = redirect_valid && (state_q != S_HALT);
  assign fetch_misalign = misalign_q;
`else
  assign redirect_s     = redirect_valid;
  assign fetch_misalign = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    drop_d      = drop_q;
    misalign_d  = misalign_q;
    fifo_wr_d   = fifo_wr_q;
    fifo_rd_d   = fifo_rd_q;
    tag_wr_d    = tag_wr_q;
    tag_rd_d    = tag_rd_q;
    fifo_push_s = 1'b0;
    tag_push_s  = 1'b0;
    out_d       = out_q + {{(CNT_W-1){1'b0}}, req_fire_s} - {{(CNT_W-1){1'b0}}, rsp_fire_s};

    if (redirect_s) begin
      // Everything buffered or in flight is stale; responses still owed are counted as drops.
      fifo_wr_d = '0;
      fifo_rd_d = '0;
      tag_wr_d  = '0;
      tag_rd_d  = '0;
      pc_d      = {redirect_pc[31:2], 2'b00};
      drop_d    = out_d;
      state_d   = (out_d == '0) ? S_RUN : S_DRAIN;
`ifdef IF_MISALIGN_EN
      if (redirect_pc[1:0] != 2'b00) begin
        misalign_d = 1'b1;
        state_d    = S_HALT;
      end else begin
        misalign_d = misalign_q;
      end
`endif
    end else begin
      if (req_fire_s) begin
        pc_d       = pc_q + 32'd4;
        tag_push_s = 1'b1;
        tag_wr_d   = tag_inc(tag_wr_q);
      end else begin
        pc_d = pc_q;
      end
      case (state_q)
        S_RUN: begin
          if (rsp_fire_s) begin
            fifo_push_s = 1'b1;
            fifo_wr_d   = fifo_wr_q + CNT_W'(1);
            tag_rd_d    = tag_inc(tag_rd_q);
          end else begin
            fifo_push_s = 1'b0;
          end
        end
        S_DRAIN: begin
          if (rsp_fire_s) begin
            drop_d  = drop_q - CNT_W'(1);
            state_d = (drop_q == CNT_W'(1)) ? S_RUN : S_DRAIN;
          end else begin
            drop_d = drop_q;
          end
        end
`ifdef IF_MISALIGN_EN
        S_HALT: begin
          if (rsp_fire_s && (drop_q != '0)) begin
            drop_d = drop_q - CNT_W'(1);
          end else begin
            drop_d = drop_q;
          end
        end
`endif
        default: state_d = S_RUN;
      endcase
      if (pop_s) begin
        fifo_rd_d = fifo_rd_q + CNT_W'(1);
      end else begin
        fifo_rd_d = fifo_rd_q;
      end
    end

    fifo_cnt_d  = fifo_wr_d - fifo_rd_d;
    sum_d       = {1'b0, out_d} + {1'b0, fifo_cnt_d};
    req_valid_d = (state_d == S_RUN) && (sum_d < (CNT_W+1)'(FIFO_DEPTH)) &&
                  (out_d < CNT_W'(MAX_OUTSTANDING));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_RUN;
      pc_q        <= RESET_PC;
      out_q       <= '0;
      drop_q      <= '0;
      req_valid_q <= 1'b0;
      misalign_q  <= 1'b0;
      fifo_wr_q   <= '0;
      fifo_rd_q   <= '0;
      tag_wr_q    <= '0;
      tag_rd_q    <= '0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      out_q       <= out_d;
      drop_q      <= drop_d;
      req_valid_q <= req_valid_d;
      misalign_q  <= misalign_d;
      fifo_wr_q   <= fifo_wr_d;
      fifo_rd_q   <= fifo_rd_d;
      tag_wr_q    <= tag_wr_d;
      tag_rd_q    <= tag_rd_d;
    end
  end

  always_ff @(posedge clk) begin
    if (fifo_push_s) begin
      fifo_inst_q[fifo_wr_q[PTR_W-1:0]] <= imem_rsp_data;
      fifo_pc_q[fifo_wr_q[PTR_W-1:0]]   <= tag_pc_q[tag_rd_q];
    end
    if (tag_push_s) begin
      tag_pc_q[tag_wr_q] <= pc_q;
    end
  end

endmodule

// File: tb/tb_if_stage.sv
// Directed bench for if_stage: memory model with configurable latency plus a PC reference stream.
module tb_if_stage;
  logic        clk = 1'b0;
  logic        rst, imem_req_valid, imem_req_ready, imem_rsp_valid;
  logic [31:0] imem_req_addr, imem_rsp_data, inst, inst_pc, redirect_pc;
  logic        inst_valid, inst_ready, redirect_valid, fetch_misalign;

  if_stage dut (
    .clk(clk), .rst(rst),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready), .imem_req_addr(imem_req_addr),
    .imem_rsp_valid(imem_rsp_valid), .imem_rsp_data(imem_rsp_data),
    .inst_valid(inst_valid), .inst_ready(inst_ready), .inst(inst), .inst_pc(inst_pc),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .fetch_misalign(fetch_misalign)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
  endfunction

  function automatic logic [31:0] tgt(input logic [31:0] p);
    return {p[31:2], 2'b00};
  endfunction

  // Instruction memory: in-order responses, latency >= 1 cycle, optional hold.
  logic [31:0] q_addr[$];
  int          q_due[$];
  int          cyc = 0, last_due = 0, lat, due;
  bit          mem_hold = 1'b0, mem_rand = 1'b0;
  int          mem_lat = 1;
  always @(posedge clk) begin
    cyc = cyc + 1;
    if (rst) begin
      q_addr.delete();
      q_due.delete();
      last_due = 0;
      imem_rsp_valid <= 1'b0;
      imem_rsp_data  <= 32'h0;
    end else begin
      if (imem_req_valid && imem_req_ready) begin
        lat = mem_rand ? int'($urandom_range(1, 3)) : mem_lat;
        due = cyc + lat - 1;
        if (due <= last_due) due = last_due + 1;
        last_due = due;
        q_addr.push_back(imem_req_addr);
        q_due.push_back(due);
      end
      if (q_addr.size() > 0 && q_due[0] <= cyc && !mem_hold) begin
        imem_rsp_valid <= 1'b1;
        imem_rsp_data  <= mem_word(q_addr.pop_front());
        void'(q_due.pop_front());
      end else begin
        imem_rsp_valid <= 1'b0;
        imem_rsp_data  <= 32'hDEAD_BEEF;
      end
    end
  end

  // Reference PC stream for requests and delivered instructions.
  logic [31:0] exp_pc, exp_req;
  int pops = 0, reqs = 0;
  always @(negedge clk) begin
    if (rst) begin
      exp_pc  = 32'h8000_0000;
      exp_req = 32'h8000_0000;
    end else begin
      if (imem_req_valid && imem_req_ready) begin
        reqs++;
        check("req_addr", imem_req_addr, exp_req);
        exp_req = exp_req + 32'd4;
      end
      if (redirect_valid) begin
        check("inst_valid_in_redirect", {31'b0, inst_valid}, 32'h0);
        exp_req = tgt(redirect_pc);
        exp_pc  = tgt(redirect_pc);
      end else if (inst_valid && inst_ready) begin
        pops++;
        check("inst_pc", inst_pc, exp_pc);
        check("inst", inst, mem_word(exp_pc));
        exp_pc = exp_pc + 32'd4;
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_req(input int max);
    int i = 0;
    while (!imem_req_valid && i < max) begin
      tick();
      i++;
    end
    check("wait_req", {31'b0, imem_req_valid}, 32'h1);
  endtask

  task automatic wait_inst(input int max);
    int i = 0;
    while (!inst_valid && i < max) begin
      tick();
      i++;
    end
    check("wait_inst", {31'b0, inst_valid}, 32'h1);
  endtask

  task automatic redirect(input logic [31:0] p);
    redirect_valid = 1'b1;
    redirect_pc    = p;
    tick();
    redirect_valid = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "timeout");
  end

  int p0, n;
  initial begin
    rst = 1'b1; imem_req_ready = 1'b0; inst_ready = 1'b0;
    redirect_valid = 1'b0; redirect_pc = 32'h0;
    repeat (3) tick();
    check("rst_req_valid", {31'b0, imem_req_valid}, 32'h0);
    check("rst_inst_valid", {31'b0, inst_valid}, 32'h0);
    check("rst_misalign", {31'b0, fetch_misalign}, 32'h0);
    check("rst_addr", imem_req_addr, 32'h8000_0000);

    // Decode stalled from reset: exactly FIFO_DEPTH fetches, then issue stops.
    imem_req_ready = 1'b1;
    reqs = 0;
    rst = 1'b0;
    repeat (12) tick();
    check("stall_reqs", reqs, 32'd4);
    check("stall_req_valid", {31'b0, imem_req_valid}, 32'h0);
    check("stall_inst_valid", {31'b0, inst_valid}, 32'h1);
    check("stall_inst_pc", inst_pc, 32'h8000_0000);

    // Release: one instruction per cycle in steady state.
    inst_ready = 1'b1;
    repeat (8) tick();
    p0 = pops;
    repeat (20) tick();
    check("throughput", pops - p0, 32'd20);

    // Two requests held in flight, then redirect to 0x100.
    mem_hold = 1'b1;
    repeat (4) tick();
    check("hold_req_valid", {31'b0, imem_req_valid}, 32'h0);
    redirect(32'h0000_0100);
    mem_hold = 1'b0;
    check("drain_no_req", {31'b0, imem_req_valid}, 32'h0);
    wait_req(20);
    check("redir_addr", imem_req_addr, 32'h0000_0100);
    wait_inst(20);
    check("redir_inst_pc", inst_pc, 32'h0000_0100);
    check("redir_inst", inst, mem_word(32'h0000_0100));

    // Redirect coinciding with a response and a request acceptance.
    repeat (10) tick();
    check("steady_fire", {31'b0, imem_req_valid & imem_rsp_valid}, 32'h1);
    redirect(32'h0000_2000);
    check("same_cycle_drain", {31'b0, imem_req_valid}, 32'h0);
    wait_inst(20);
    check("same_cycle_inst_pc", inst_pc, 32'h0000_2000);

    // Random ready/latency with occasional redirects; the reference stream checks order.
    mem_rand = 1'b1;
    p0 = pops;
    for (int i = 0; i < 300; i++) begin
      imem_req_ready = 1'($urandom_range(0, 1));
      inst_ready     = 1'($urandom_range(0, 1));
      if (i == 100 || i == 200) begin
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_4000 + 32'(i);
      end else begin
        redirect_valid = 1'b0;
      end
      tick();
    end
    redirect_valid = 1'b0; imem_req_ready = 1'b1; inst_ready = 1'b1; mem_rand = 1'b0;
    repeat (20) tick();
    check("random_progress", {31'b0, (pops - p0) > 30}, 32'h1);

    // PC wraps modulo 2^32.
    redirect(32'hFFFF_FFF8);
    repeat (12) tick();
    check("wrap_inst_pc", inst_pc, exp_pc);

    // Misaligned redirect.
    redirect(32'h0000_0102);
`ifdef IF_MISALIGN_EN
    check("misalign_set", {31'b0, fetch_misalign}, 32'h1);
    n = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (imem_req_valid || inst_valid) n++;
    end
    check("halt_quiet", n, 32'd0);
    redirect(32'h0000_0300);
    repeat (3) tick();
    check("halt_ignores_redirect", {31'b0, imem_req_valid}, 32'h0);
    check("misalign_sticky", {31'b0, fetch_misalign}, 32'h1);
`else
    check("misalign_tied", {31'b0, fetch_misalign}, 32'h0);
    wait_req(20);
    check("misalign_addr", imem_req_addr, 32'h0000_0100);
    wait_inst(20);
    check("misalign_inst_pc", inst_pc, 32'h0000_0100);
`endif

    // Reset while draining stale responses.
    mem_hold = 1'b1;
    repeat (4) tick();
    redirect(32'h0000_0500);
    rst = 1'b1;
    tick();
    mem_hold = 1'b0;
    tick();
    check("rst2_req_valid", {31'b0, imem_req_valid}, 32'h0);
    check("rst2_inst_valid", {31'b0, inst_valid}, 32'h0);
    check("rst2_misalign", {31'b0, fetch_misalign}, 32'h0);
    rst = 1'b0;
    wait_req(20);
    check("rst2_addr", imem_req_addr, 32'h8000_0000);
    wait_inst(20);
    check("rst2_inst_pc", inst_pc, 32'h8000_0000);
    repeat (5) tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
